// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core and its BCD digit counters.
package stopwatch_pkg;

  // Run/pause state of the stopwatch.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_SAT   = 2'd3
  } sw_state_e;

  // One BCD digit.
  typedef logic [3:0] bcd_digit_t;

  // Four-digit MM:SS time value, most significant digit first.
  typedef struct packed {
    bcd_digit_t min_tens;
    bcd_digit_t min_ones;
    bcd_digit_t sec_tens;
    bcd_digit_t sec_ones;
  } bcd_time_t;

  localparam bcd_digit_t DIGIT_MAX_ONES = 4'd9;
  localparam bcd_digit_t DIGIT_MAX_TENS = 4'd5;

  // True when the time value reads 59:59.
  function automatic logic bcd_time_is_max(input bcd_time_t t);
    return (t.min_tens == DIGIT_MAX_TENS) && (t.min_ones == DIGIT_MAX_ONES) &&
           (t.sec_tens == DIGIT_MAX_TENS) && (t.sec_ones == DIGIT_MAX_ONES);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter 0..MAX with synchronous clear and a combinational
// carry-out, meant to be chained into a ripple of digits.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_digit_t MAX = DIGIT_MAX_ONES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output bcd_digit_t digit,
  output logic       carry
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  // Next digit value: clear wins, otherwise step and wrap at MAX.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc) begin
      // Treat anything at or above MAX as the wrap point so the digit can never
      // drift out of its legal range.
      if (digit_q >= MAX) begin
        digit_d = 4'd0;
      end else begin
        digit_d = digit_q + 4'd1;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc && (digit_q >= MAX);

endmodule

// File: rtl/stopwatch_bcd_core.sv
// Stopwatch timebase and MM:SS BCD counter with start/stop/clear control.
// A prescaler divides clk into one-second ticks; four chained BCD digit
// counters hold the time. SATURATE selects wrap-with-pulse or hold-at-59:59.
// Optional macro STOPWATCH_LAP_EN adds a lap-hold display freeze.
module stopwatch_bcd_core
  import stopwatch_pkg::*;
#(
  parameter int CLKS_PER_TICK = 100000000,
  parameter int SATURATE      = 0,
  parameter int PRESC_W       = $clog2(CLKS_PER_TICK)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic       lap_held,
`endif
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       tick,
  output logic       overflow
);

  localparam logic                SAT_EN     = (SATURATE != 0);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_TICK - 1);

  sw_state_e          state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;
  logic               ovf_q, ovf_d;
  logic               running_q, running_d;

  logic      run_adv_s;
  logic      term_s;
  logic      at_max_s;
  logic      cnt_inc_s;
  logic      so_carry_s, st_carry_s, mo_carry_s, mt_carry_s;
  bcd_digit_t so_s, st_s, mo_s, mt_s;
  bcd_time_t live_s;
  bcd_time_t disp_s;

  // The counter only advances in RUN when neither stop nor clear overrides it.
  assign run_adv_s = (state_q == ST_RUN) && !stop && !clear;
  assign term_s    = (presc_q == PRESC_LAST);
  assign live_s    = '{min_tens: mt_s, min_ones: mo_s, sec_tens: st_s, sec_ones: so_s};
  assign at_max_s  = bcd_time_is_max(live_s);

  // Prescaler, tick and digit-increment decisions.
  always_comb begin
    presc_d   = presc_q;
    tick_d    = 1'b0;
    cnt_inc_s = 1'b0;
    if (clear) begin
      presc_d = '0;
    end else if (run_adv_s) begin
      if (term_s) begin
        presc_d = '0;
        tick_d  = 1'b1;
        // In saturating mode the digits stay parked at 59:59.
        cnt_inc_s = !(SAT_EN && at_max_s);
      end else begin
        presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Overflow: a pulse on wrap, or a sticky flag when saturating.
  always_comb begin
    ovf_d = 1'b0;
    if (SAT_EN) begin
      if (clear) begin
        ovf_d = 1'b0;
      end else if (tick_d && at_max_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      // The top digit only carries when the whole chain rolls over 59:59.
      ovf_d = mt_carry_s;
    end
  end

  // Next-state logic; priority is clear, then stop, then start.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (SAT_EN && tick_d && at_max_s) begin
            state_d = ST_SAT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (start && !stop) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_SAT: begin
          state_d = ST_SAT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  // Control registers: state, prescaler and the registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
    end
  end

  bcd_digit_counter #(.MAX(DIGIT_MAX_ONES)) u_sec_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (cnt_inc_s),
    .digit (so_s),
    .carry (so_carry_s)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_TENS)) u_sec_tens (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (so_carry_s),
    .digit (st_s),
    .carry (st_carry_s)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_ONES)) u_min_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (st_carry_s),
    .digit (mo_s),
    .carry (mo_carry_s)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_TENS)) u_min_tens (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (mo_carry_s),
    .digit (mt_s),
    .carry (mt_carry_s)
  );

`ifdef STOPWATCH_LAP_EN
  logic      held_q, held_d;
  bcd_time_t shadow_q, shadow_d;
  logic      lap_act_s;

  // Lap is honoured only while running and only when stop/clear do not win.
  assign lap_act_s = run_adv_s && lap;

  // Lap hold toggle and shadow capture of the pre-tick live time.
  always_comb begin
    held_d   = held_q;
    shadow_d = shadow_q;
    if (clear) begin
      held_d   = 1'b0;
      shadow_d = '0;
    end else if (lap_act_s) begin
      held_d = !held_q;
      if (!held_q) begin
        shadow_d = live_s;
      end else begin
        shadow_d = shadow_q;
      end
    end else begin
      held_d   = held_q;
      shadow_d = shadow_q;
    end
  end

  // Lap hold and shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      held_q   <= held_d;
      shadow_q <= shadow_d;
    end
  end

  assign disp_s   = held_q ? shadow_q : live_s;
  assign lap_held = held_q;
`else
  assign disp_s = live_s;
`endif

  assign min_tens = disp_s.min_tens;
  assign min_ones = disp_s.min_ones;
  assign sec_tens = disp_s.sec_tens;
  assign sec_ones = disp_s.sec_ones;
  assign running  = running_q;
  assign tick     = tick_q;
  assign overflow = ovf_q;

endmodule
